// File: rtl/bus_arbiter_rr.sv
// Round-robin N-master bus arbiter: registered one-hot grant, released by the owner's free strobe.
// Optional grant watchdog under BUS_ARB_WATCHDOG_EN; revocation pulses bus_error for one cycle.
module bus_arbiter_rr #(
  parameter int N_MASTERS      = 3,
  parameter int ID_W           = 2,
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_MASTERS-1:0] bus_req,
  input  logic [N_MASTERS-1:0] bus_free,
  output logic [N_MASTERS-1:0] bus_grant,
  output logic [ID_W-1:0]      grant_id,
  output logic                 bus_busy,
  output logic                 bus_error
);

  if ((1 << ID_W) < N_MASTERS) begin : g_bad_id_w
    $error("ID_W too narrow for N_MASTERS");
  end
  if ((1 << CNT_W) <= TIMEOUT_CYCLES) begin : g_bad_cnt_w
    $error("CNT_W too narrow for TIMEOUT_CYCLES");
  end

  typedef enum logic {IDLE, GRANT} state_t;

  state_t                state, state_nxt;
  logic [ID_W-1:0]       last_id, last_nxt, id_nxt, winner;
  logic [N_MASTERS-1:0]  grant_nxt;
  logic                  busy_nxt, error_nxt, found, owner_free, timeout;
  int                    idx;

  // Only the current owner's free bit can match the one-hot grant.
  assign owner_free = |(bus_free & bus_grant);

  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    for (int i = 1; i <= N_MASTERS; i++) begin
      idx = (int'(last_id) + i) % N_MASTERS;
      if (!found && bus_req[idx]) begin
        found  = 1'b1;
        winner = ID_W'(idx);
      end
    end
  end

`ifdef BUS_ARB_WATCHDOG_EN
  logic [CNT_W-1:0] wd_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)              wd_cnt <= '0;
    else if (state == IDLE) wd_cnt <= '0;
    else if (!owner_free)   wd_cnt <= wd_cnt + CNT_W'(1);
  end

  assign timeout = (wd_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    grant_nxt = bus_grant;
    id_nxt    = grant_id;
    last_nxt  = last_id;
    busy_nxt  = bus_busy;
    error_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (found) begin
          grant_nxt         = '0;
          grant_nxt[winner] = 1'b1;
          id_nxt            = winner;
          last_nxt          = winner;
          busy_nxt          = 1'b1;
          state_nxt         = GRANT;
        end
      end
      GRANT: begin
        // Free beats a coincident timeout; last_id keeps the offender at lowest priority.
        if (owner_free || timeout) begin
          grant_nxt = '0;
          busy_nxt  = 1'b0;
          error_nxt = !owner_free;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      bus_grant <= '0;
      grant_id  <= '0;
      last_id   <= ID_W'(N_MASTERS - 1);
      bus_busy  <= 1'b0;
      bus_error <= 1'b0;
    end else begin
      state     <= state_nxt;
      bus_grant <= grant_nxt;
      grant_id  <= id_nxt;
      last_id   <= last_nxt;
      bus_busy  <= busy_nxt;
      bus_error <= error_nxt;
    end
  end

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Directed self-checking bench for bus_arbiter_rr (3 masters, TIMEOUT_CYCLES=16).
module tb_bus_arbiter_rr;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] bus_req;
  logic [2:0] bus_free;
  logic [2:0] bus_grant;
  logic [1:0] grant_id;
  logic       bus_busy;
  logic       bus_error;

  int total = 0;
  int bad   = 0;

  bus_arbiter_rr #(
    .N_MASTERS(3), .ID_W(2), .TIMEOUT_CYCLES(16), .CNT_W(8)
  ) dut (
    .clk(clk), .reset(reset), .bus_req(bus_req), .bus_free(bus_free),
    .bus_grant(bus_grant), .grant_id(grant_id), .bus_busy(bus_busy),
    .bus_error(bus_error)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    bus_req  = '0;
    bus_free = '0;
    reset    = 1'b1;
    tick();
    tick();
    reset    = 1'b0;
    tick();
  endtask

  task automatic test_reset;
    bus_req  = '0;
    bus_free = '0;
    reset    = 1'b1;
    #3;
    total++; if (bus_grant !== 3'b000) begin bad++; $display("FAIL reset_grant got=%b want=000", bus_grant); end
    total++; if (grant_id !== 2'd0)    begin bad++; $display("FAIL reset_id got=%0d want=0", grant_id); end
    total++; if (bus_busy !== 1'b0)    begin bad++; $display("FAIL reset_busy got=%b want=0", bus_busy); end
    total++; if (bus_error !== 1'b0)   begin bad++; $display("FAIL reset_error got=%b want=0", bus_error); end
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_single;
    bus_req = 3'b001;
    tick();
    total++; if (bus_grant !== 3'b001) begin bad++; $display("FAIL single_grant got=%b want=001", bus_grant); end
    total++; if (grant_id !== 2'd0)    begin bad++; $display("FAIL single_id got=%0d want=0", grant_id); end
    total++; if (bus_busy !== 1'b1)    begin bad++; $display("FAIL single_busy got=%b want=1", bus_busy); end
    bus_req = 3'b000;
    tick();
    tick();
    bus_free = 3'b001;
    tick();
    bus_free = 3'b000;
    total++; if (bus_grant !== 3'b000) begin bad++; $display("FAIL single_release got=%b want=000", bus_grant); end
    total++; if (bus_busy !== 1'b0)    begin bad++; $display("FAIL single_rel_busy got=%b want=0", bus_busy); end
    tick();
    total++; if (grant_id !== 2'd0)    begin bad++; $display("FAIL single_id_hold got=%0d want=0", grant_id); end
  endtask

  task automatic test_round_robin;
    logic [2:0] exp_seq [4];
    logic [1:0] exp_id  [4];
    exp_seq = '{3'b001, 3'b010, 3'b100, 3'b001};
    exp_id  = '{2'd0, 2'd1, 2'd2, 2'd0};
    do_reset();
    bus_req = 3'b111;
    for (int k = 0; k < 4; k++) begin
      tick();
      total++; if (bus_grant !== exp_seq[k]) begin bad++; $display("FAIL rr_grant[%0d] got=%b want=%b", k, bus_grant, exp_seq[k]); end
      total++; if (grant_id !== exp_id[k])   begin bad++; $display("FAIL rr_id[%0d] got=%0d want=%0d", k, grant_id, exp_id[k]); end
      tick();
      bus_free = exp_seq[k];
      tick();
      bus_free = 3'b000;
      total++; if (bus_grant !== 3'b000) begin bad++; $display("FAIL rr_gap[%0d] got=%b want=000", k, bus_grant); end
    end
    bus_req = 3'b000;
    tick();
  endtask

  task automatic test_nonowner_free;
    do_reset();
    bus_req = 3'b010;
    tick();
    total++; if (bus_grant !== 3'b010) begin bad++; $display("FAIL nof_grant got=%b want=010", bus_grant); end
    bus_req  = 3'b000;
    bus_free = 3'b101;
    tick();
    tick();
    total++; if (bus_grant !== 3'b010) begin bad++; $display("FAIL nof_hold got=%b want=010", bus_grant); end
    bus_free = 3'b010;
    tick();
    bus_free = 3'b000;
    total++; if (bus_grant !== 3'b000) begin bad++; $display("FAIL nof_release got=%b want=000", bus_grant); end
    total++; if (grant_id !== 2'd1)    begin bad++; $display("FAIL nof_id_hold got=%0d want=1", grant_id); end
  endtask

  task automatic test_drop_and_reset;
    do_reset();
    bus_req = 3'b100;
    tick();
    total++; if (grant_id !== 2'd2) begin bad++; $display("FAIL drop_id got=%0d want=2", grant_id); end
    bus_req = 3'b000;
    tick();
    tick();
    tick();
    total++; if (bus_grant !== 3'b100) begin bad++; $display("FAIL drop_hold got=%b want=100", bus_grant); end
    reset = 1'b1;
    #2;
    total++; if (bus_grant !== 3'b000) begin bad++; $display("FAIL midrst_grant got=%b want=000", bus_grant); end
    total++; if (bus_busy !== 1'b0 || grant_id !== 2'd0 || bus_error !== 1'b0) begin
      bad++; $display("FAIL midrst_outs got busy=%b id=%0d err=%b want 0/0/0", bus_busy, grant_id, bus_error);
    end
    bus_req = 3'b111;
    #2;
    reset = 1'b0;
    tick();
    total++; if (bus_grant !== 3'b001) begin bad++; $display("FAIL midrst_next got=%b want=001", bus_grant); end
    bus_req  = 3'b000;
    bus_free = 3'b001;
    tick();
    bus_free = 3'b000;
  endtask

`ifdef BUS_ARB_WATCHDOG_EN
  task automatic test_watchdog;
    int held;
    int errs;
    do_reset();
    bus_req = 3'b001;
    tick();
    bus_req = 3'b011;
    held = 1;
    errs = 0;
    for (int k = 1; k < 16; k++) begin
      tick();
      if (bus_grant == 3'b001) held++;
      if (bus_error !== 1'b0) errs++;
    end
    total++; if (held != 16 || errs != 0) begin bad++; $display("FAIL wd_hold got held=%0d errs=%0d want 16/0", held, errs); end
    tick();
    total++; if (bus_grant !== 3'b000 || bus_error !== 1'b1) begin
      bad++; $display("FAIL wd_revoke got grant=%b err=%b want 000/1", bus_grant, bus_error);
    end
    tick();
    total++; if (bus_error !== 1'b0)   begin bad++; $display("FAIL wd_pulse got=%b want=0", bus_error); end
    total++; if (bus_grant !== 3'b010) begin bad++; $display("FAIL wd_next got=%b want=010", bus_grant); end
    bus_req  = 3'b000;
    bus_free = 3'b010;
    tick();
    bus_free = 3'b000;
  endtask

  task automatic test_watchdog_free_edge;
    do_reset();
    bus_req = 3'b001;
    tick();
    bus_req = 3'b000;
    for (int k = 1; k < 16; k++) tick();
    bus_free = 3'b001;
    tick();
    bus_free = 3'b000;
    total++; if (bus_grant !== 3'b000 || bus_error !== 1'b0) begin
      bad++; $display("FAIL wd_free_edge got grant=%b err=%b want 000/0", bus_grant, bus_error);
    end
    tick();
    total++; if (bus_error !== 1'b0) begin bad++; $display("FAIL wd_free_after got=%b want=0", bus_error); end
  endtask
`else
  task automatic test_no_watchdog;
    int held;
    int errs;
    do_reset();
    bus_req = 3'b001;
    tick();
    bus_req = 3'b011;
    held = 0;
    errs = 0;
    for (int k = 0; k < 120; k++) begin
      tick();
      if (bus_grant == 3'b001) held++;
      if (bus_error !== 1'b0) errs++;
    end
    total++; if (held != 120) begin bad++; $display("FAIL nowd_hold got=%0d want=120", held); end
    total++; if (errs != 0)   begin bad++; $display("FAIL nowd_error got=%0d want=0", errs); end
    bus_req  = 3'b000;
    bus_free = 3'b001;
    tick();
    bus_free = 3'b000;
  endtask
`endif

  initial begin
    reset    = 1'b1;
    bus_req  = '0;
    bus_free = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_nonowner_free();
    test_drop_and_reset();
`ifdef BUS_ARB_WATCHDOG_EN
    test_watchdog();
    test_watchdog_free_edge();
`else
    test_no_watchdog();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bus_arbiter_rr.md
Name: bus_arbiter_rr

Overview:
Parametrised N-master system-bus arbiter that supersedes the fixed three-requester scheme (io / L2cache / uncache).
- Masters raise a request, receive a registered one-hot grant, and release the bus with a free strobe.
- Arbitration is round-robin, so no master can be starved.
- Sits between the bus masters and the shared address/data bus mux; grant_id drives that mux select.

Parameters:
N_MASTERS, 3, number of requesting masters (2..16)
ID_W, 2, width of grant_id; must satisfy 2**ID_W >= N_MASTERS
TIMEOUT_CYCLES, 16, max cycles a grant may be held without free (only with watchdog)
CNT_W, 8, watchdog counter width; must satisfy 2**CNT_W > TIMEOUT_CYCLES

Ports:
clk  in  1  system clock; all state updates on rising edge
reset  in  1  asynchronous, active-high reset
bus_req  in  N_MASTERS  per-master request, level
bus_free  in  N_MASTERS  per-master release strobe; only the owner's bit is honoured
bus_grant  out  N_MASTERS  one-hot grant, registered
grant_id  out  ID_W  index of current owner; valid while bus_busy=1
bus_busy  out  1  high while any grant is active
bus_error  out  1  one-cycle pulse on watchdog revocation

Behaviour:
Interface facts:
- One clock, clk. Reset is asynchronous and active-high, on port reset.

Reset values (take effect immediately on reset assertion, including mid-grant):
- bus_grant=0, grant_id=0, bus_busy=0, bus_error=0, state=IDLE, watchdog counter=0.
- last_id=N_MASTERS-1, so master 0 has top priority after reset.
- An in-flight grant is dropped without any error pulse.

State machine, 2 states:
- IDLE:
  - If bus_req != 0 at a rising edge, select the winner: search from (last_id+1) mod N_MASTERS upward with wrap, first set bit wins.
  - At that same edge: bus_grant=onehot(winner), grant_id=winner, bus_busy=1, last_id=winner; go to GRANT.
  - Latency is 1 edge: request sampled at edge k, grant visible after edge k.
- GRANT:
  - bus_req is ignored for all masters.
  - If bus_free[grant_id]=1 at an edge: bus_grant=0, bus_busy=0, go to IDLE.
  - bus_free on non-owner bits is ignored.
  - The owner dropping bus_req without free does NOT release the bus.
- Turnaround: at least one idle cycle (bus_grant=0) between consecutive owners, even when requests are pending. This gives bus-driver turnaround.

Invariants:
- bus_grant is always one-hot or zero.
- grant_id holds its last value while idle.
- The winner index never exceeds N_MASTERS-1.
- Free bits and request bits at or above N_MASTERS do not exist, since port widths are exactly N_MASTERS.

Simultaneous events:
- free and a new request in the same cycle: release first; the new request is arbitrated in the following IDLE cycle.
- Sole requester: re-granted after the one-cycle gap. Round-robin wraps back to the same master.

Optional Feature:
Macro: BUS_ARB_WATCHDOG_EN

Defined:
- Counter clears on entry to GRANT and increments each GRANT cycle without owner free.
- When the counter reaches TIMEOUT_CYCLES-1 and free is still absent, at the next edge:
  - bus_grant=0, bus_busy=0, bus_error=1 for exactly one cycle, go to IDLE.
  - last_id stays at the offender, so the offender has the lowest priority next.
- If free arrives on the same edge as the timeout, free wins: normal release, no error.

Not defined:
- No counter logic. bus_error is tied to 0.
- Grants are held indefinitely until free.

Test Plan:
1. Reset then bus_req=3'b001 at edge 1 -> bus_grant=3'b001, grant_id=0, bus_busy=1 after edge 1. bus_free=3'b001 at edge 4 -> grant=0 after edge 4.
2. bus_req=3'b111 held, each owner frees after 2 cycles -> grant order 001,010,100,001 with exactly one zero-grant cycle between owners.
3. Owner 1 granted, bus_free=3'b101 (non-owner bits only) -> grant stays 3'b010. Then bus_free=3'b010 -> released.
4. Owner 2 drops bus_req without free -> grant 3'b100 held. Assert reset mid-grant -> all outputs 0 immediately, next grant goes to master 0.
5. With BUS_ARB_WATCHDOG_EN, TIMEOUT_CYCLES=16: master 0 never frees -> revoked after 16 GRANT cycles with bus_error pulse width 1. Pending bus_req=3'b011 -> master 1 is granted next.
6. With BUS_ARB_WATCHDOG_EN: free on the exact timeout edge -> normal release, bus_error stays 0. Without the macro, same stimulus as 5 -> grant held more than 100 cycles, bus_error=0.
